// File: rtl/seg_display_ctrl_if.sv
// Device-side common bus slice (address, strobed write, registered read) for seg_display_ctrl.
interface seg_display_ctrl_if;
   logic [31:0] addr;
   logic        ren;
   logic [31:0] rdata;
   logic        wen;
   logic [31:0] wdata;
   logic [3:0]  wstrb;

   modport master (output addr, ren, wen, wdata, wstrb, input rdata);
   modport slave  (input addr, ren, wen, wdata, wstrb, output rdata);
endinterface

// File: rtl/seg_display_ctrl.sv
// Memory-mapped 8-digit hex seven-segment controller scanning two 4-digit banks.
// Build option SEG_LEADING_ZERO_BLANK_EN adds CTRL.BLANK leading-zero suppression.
module seg_display_ctrl #(
   parameter int unsigned SCAN_DIV = 50000,
   parameter logic [3:0]  BASE_OFF = 4'h0
) (
   input  logic              clk,
   input  logic              rst_n,
   seg_display_ctrl_if.slave bus,
   output logic [7:0]        seg0,
   output logic [7:0]        seg1,
   output logic [3:0]        sel0,
   output logic [3:0]        sel1
);
   localparam int unsigned     PreW   = $clog2(SCAN_DIV);
   localparam logic [PreW-1:0] PreMax = PreW'(SCAN_DIV - 1);

   logic [31:0]     data_q, data_d, shadow_q, shadow_d, rdata_q, rdata_d;
   logic [7:0]      dp_q, dp_d, sdp_q, sdp_d;
   logic            en_q, en_d, tick_q, tick_d;
   logic [PreW-1:0] pre_q, pre_d;
   logic [1:0]      slot_q, slot_d;
   logic [7:0]      seg0_q, seg0_d, seg1_q, seg1_d;
   logic [3:0]      sel0_q, sel0_d, sel1_q, sel1_d;

   logic        acc_ok, rd, wr, pre_wrap, frame_wrap;
   logic [1:0]  reg_sel;
   logic [31:0] wmask;
   logic [7:0]  blank_mask;
   logic [2:0]  lo_idx, hi_idx;
   logic        unused_addr;

   assign unused_addr = ^{bus.addr[31:8], bus.addr[1:0]};

`ifdef SEG_LEADING_ZERO_BLANK_EN
   logic blank_q, blank_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) blank_q <= 1'b0;
      else        blank_q <= blank_d;
   end

   always_comb begin
      blank_d = blank_q;
      if (wr && reg_sel == 2'd1 && bus.wstrb[0]) blank_d = bus.wdata[1];
   end
`else
   logic blank_q;
   assign blank_q = 1'b0;
`endif

   function automatic logic [6:0] hex7(input logic [3:0] nib);
      logic [6:0] s;
      case (nib)
         4'h0: s = 7'h3F;  4'h1: s = 7'h06;  4'h2: s = 7'h5B;  4'h3: s = 7'h4F;
         4'h4: s = 7'h66;  4'h5: s = 7'h6D;  4'h6: s = 7'h7D;  4'h7: s = 7'h07;
         4'h8: s = 7'h7F;  4'h9: s = 7'h6F;  4'hA: s = 7'h77;  4'hB: s = 7'h7C;
         4'hC: s = 7'h39;  4'hD: s = 7'h5E;  4'hE: s = 7'h79;  default: s = 7'h71;
      endcase
      return s;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q   <= '0;
         shadow_q <= '0;
         rdata_q  <= '0;
         dp_q     <= '0;
         sdp_q    <= '0;
         en_q     <= 1'b0;
         tick_q   <= 1'b0;
         pre_q    <= '0;
         slot_q   <= '0;
         seg0_q   <= '0;
         seg1_q   <= '0;
         sel0_q   <= '0;
         sel1_q   <= '0;
      end else begin
         data_q   <= data_d;
         shadow_q <= shadow_d;
         rdata_q  <= rdata_d;
         dp_q     <= dp_d;
         sdp_q    <= sdp_d;
         en_q     <= en_d;
         tick_q   <= tick_d;
         pre_q    <= pre_d;
         slot_q   <= slot_d;
         seg0_q   <= seg0_d;
         seg1_q   <= seg1_d;
         sel0_q   <= sel0_d;
         sel1_q   <= sel1_d;
      end
   end

   always_comb begin
      acc_ok     = bus.addr[7:4] == BASE_OFF;
      reg_sel    = bus.addr[3:2];
      rd         = bus.ren && acc_ok;
      wr         = bus.wen && acc_ok;
      pre_wrap   = pre_q == PreMax;
      frame_wrap = pre_wrap && slot_q == 2'd3;
      for (int i = 0; i < 4; i++) wmask[8*i +: 8] = {8{bus.wstrb[i]}};

      pre_d    = pre_wrap ? '0 : pre_q + 1'b1;
      slot_d   = pre_wrap ? slot_q + 2'd1 : slot_q;
      // Display content only follows DATA/DP at frame boundaries to avoid tearing.
      shadow_d = frame_wrap ? data_q : shadow_q;
      sdp_d    = frame_wrap ? dp_q : sdp_q;

      data_d = data_q;
      en_d   = en_q;
      dp_d   = dp_q;
      if (wr && reg_sel == 2'd0) data_d = (data_q & ~wmask) | (bus.wdata & wmask);
      if (wr && reg_sel == 2'd1) begin
         if (bus.wstrb[0]) en_d = bus.wdata[0];
         if (bus.wstrb[1]) dp_d = bus.wdata[15:8];
      end

      rdata_d = rdata_q;
      if (bus.ren) begin
         rdata_d = '0;
         if (acc_ok) begin
            case (reg_sel)
               2'd0:    rdata_d = data_q;
               2'd1:    rdata_d = {16'h0, dp_q, 6'h0, blank_q, en_q};
               2'd2:    rdata_d = {29'h0, tick_q, slot_q};
               default: rdata_d = '0;
            endcase
         end
      end

      tick_d = tick_q;
      if (rd && reg_sel == 2'd2) tick_d = 1'b0;
      if (frame_wrap)            tick_d = 1'b1;
   end

   // Digit k >= 1 is blank when it and every more significant nibble are zero.
   always_comb begin
      blank_mask = '0;
      for (int k = 1; k < 8; k++) begin
         blank_mask[k] = blank_q && ((shadow_q >> (4 * k)) == 32'h0);
      end
   end

   always_comb begin
      lo_idx = {1'b0, slot_q};
      hi_idx = {1'b1, slot_q};
      sel0_d = '0;
      sel1_d = '0;
      seg0_d = '0;
      seg1_d = '0;
      if (en_q) begin
         sel0_d = 4'b0001 << slot_q;
         sel1_d = 4'b0001 << slot_q;
         seg0_d = {sdp_q[lo_idx],
                   blank_mask[lo_idx] ? 7'h00 : hex7(shadow_q[{lo_idx, 2'b00} +: 4])};
         seg1_d = {sdp_q[hi_idx],
                   blank_mask[hi_idx] ? 7'h00 : hex7(shadow_q[{hi_idx, 2'b00} +: 4])};
      end
   end

   assign bus.rdata = rdata_q;
   assign seg0      = seg0_q;
   assign seg1      = seg1_q;
   assign sel0      = sel0_q;
   assign sel1      = sel1_q;
endmodule

// File: tb/tb_seg_display_ctrl.sv
// Self-checking bench for seg_display_ctrl: directed steps then random bus traffic vs a cycle model.
module tb_seg_display_ctrl;
   localparam int unsigned D    = 4;
   localparam logic [3:0]  Base = 4'h5;

   logic       clk, rst_n;
   logic [7:0] seg0, seg1;
   logic [3:0] sel0, sel1;

   seg_display_ctrl_if bus ();

   seg_display_ctrl #(.SCAN_DIV(D), .BASE_OFF(Base)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave),
      .seg0  (seg0),
      .seg1  (seg1),
      .sel0  (sel0),
      .sel1  (sel1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          vectors = 0;
   int          fails   = 0;
   int unsigned n;
   logic [31:0] m_data, m_shadow, m_rdata;
   logic [7:0]  m_dp, m_sdp, e_seg0, e_seg1;
   logic [3:0]  e_sel0, e_sel1;
   logic        m_en, m_blank, m_tick;
   logic [6:0]  hex_tab [16];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      n = 0; m_data = '0; m_shadow = '0; m_rdata = '0; m_dp = '0; m_sdp = '0;
      m_en = 1'b0; m_blank = 1'b0; m_tick = 1'b0;
      e_seg0 = '0; e_seg1 = '0; e_sel0 = '0; e_sel1 = '0;
   endtask

   function automatic logic [7:0] digit_seg(input int k);
      logic [3:0] nib;
      logic [7:0] s;
      nib = 4'((m_shadow >> (4 * k)) & 32'hF);
      s   = {1'b0, hex_tab[nib]};
      if (m_blank && k >= 1 && (m_shadow >> (4 * k)) == 32'h0) s = 8'h00;
      if (m_sdp[k]) s[7] = 1'b1;
      return s;
   endfunction

   task automatic idle_bus();
      bus.ren = 1'b0; bus.wen = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
   endtask

   // One clock: predict from pre-edge model state, advance model, then compare.
   task automatic step();
      logic [1:0] slot;
      logic       valid;
      logic [1:0] r;
      slot  = 2'((n / D) % 4);
      valid = bus.addr[7:4] == Base;
      r     = bus.addr[3:2];
      e_sel0 = m_en ? 4'(1 << slot) : 4'h0;
      e_sel1 = e_sel0;
      e_seg0 = m_en ? digit_seg(int'(slot)) : 8'h00;
      e_seg1 = m_en ? digit_seg(int'(slot) + 4) : 8'h00;
      if (bus.ren) begin
         m_rdata = '0;
         if (valid) begin
            if (r == 2'd0) m_rdata = m_data;
            if (r == 2'd1) m_rdata = {16'h0, m_dp, 6'h0, m_blank, m_en};
            if (r == 2'd2) m_rdata = {29'h0, m_tick, slot};
         end
      end
      if (bus.ren && valid && r == 2'd2) m_tick = 1'b0;
      if (n % (4 * D) == 4 * D - 1) begin
         m_tick = 1'b1; m_shadow = m_data; m_sdp = m_dp;
      end
      if (bus.wen && valid && r == 2'd0) begin
         for (int i = 0; i < 4; i++) if (bus.wstrb[i]) m_data[8*i +: 8] = bus.wdata[8*i +: 8];
      end
      if (bus.wen && valid && r == 2'd1) begin
         if (bus.wstrb[0]) m_en = bus.wdata[0];
         if (bus.wstrb[1]) m_dp = bus.wdata[15:8];
`ifdef SEG_LEADING_ZERO_BLANK_EN
         if (bus.wstrb[0]) m_blank = bus.wdata[1];
`endif
      end
      n++;
      @(posedge clk);
      #1;
      check("sel0", 32'(sel0), 32'(e_sel0));
      check("sel1", 32'(sel1), 32'(e_sel1));
      check("seg0", 32'(seg0), 32'(e_seg0));
      check("seg1", 32'(seg1), 32'(e_seg1));
      check("rdata", bus.rdata, m_rdata);
   endtask

   task automatic idle(input int k);
      idle_bus();
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic bus_write(input logic [1:0] r, input logic [31:0] d, input logic [3:0] s);
      idle_bus();
      bus.wen = 1'b1; bus.addr = {24'h0, Base, r, 2'b00}; bus.wdata = d; bus.wstrb = s;
      step();
      idle_bus();
   endtask

   task automatic bus_read(input logic [1:0] r);
      idle_bus();
      bus.ren = 1'b1; bus.addr = {24'h0, Base, r, 2'b00};
      step();
      idle_bus();
   endtask

   // Bounded wait for a given select pattern; expiry is a failed comparison.
   task automatic wait_sel(input logic [3:0] want, input string tag);
      int k = 0;
      idle_bus();
      while (sel0 !== want && k < 4 * D + 4) begin
         step();
         k++;
      end
      check(tag, 32'(sel0), 32'(want));
   endtask

   task automatic async_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check("rst_sel0", 32'(sel0), 32'h0);
      check("rst_sel1", 32'(sel1), 32'h0);
      check("rst_seg0", 32'(seg0), 32'h0);
      check("rst_seg1", 32'(seg1), 32'h0);
      check("rst_rdata", bus.rdata, 32'h0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] blank_exp [4];
      hex_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
      blank_exp = '{8'h3F, 8'h6D, 8'h00, 8'h00};
      rst_n = 1'b0;
      idle_bus();
      model_reset();
      #3;
      check("init_sel0", 32'(sel0), 32'h0);
      check("init_seg0", 32'(seg0), 32'h0);
      check("init_rdata", bus.rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // First select after enabling is digit 0.
      idle(5);
      bus_write(2'd1, 32'h0000_0001, 4'hF);
      wait_sel(4'b0001, "first_sel0");
      idle(3);
      async_reset();

      // Full-value display across a frame.
      bus_write(2'd0, 32'h7654_3210, 4'hF);
      bus_write(2'd1, 32'h0000_0001, 4'hF);
      idle(2 * 4 * D);
      wait_sel(4'b0001, "slot0_sel");
      check("slot0_seg0", 32'(seg0), 32'h3F);
      check("slot0_seg1", 32'(seg1), 32'h66);
      wait_sel(4'b1000, "slot3_sel");
      check("slot3_seg0", 32'(seg0), 32'h4F);
      check("slot3_seg1", 32'(seg1), 32'h07);

      // Partial byte write and readback.
      bus_write(2'd0, 32'h0, 4'hF);
      idle(4 * D);
      bus_write(2'd0, 32'h0000_AB00, 4'b0010);
      bus_write(2'd0, 32'hFFFF_FFFF, 4'b0000);
      bus_read(2'd0);
      check("partial_rd", bus.rdata, 32'h0000_AB00);
      idle(4 * D + 2);

      // Decimal point on digit 7 only.
      bus_write(2'd1, 32'h0000_8001, 4'hF);
      idle(2 * 4 * D);
      wait_sel(4'b1000, "dp_sel3");
      check("dp_slot3", 32'(seg1[7]), 32'h1);
      wait_sel(4'b0001, "dp_sel0");
      check("dp_slot0", 32'(seg1[7]), 32'h0);

      // STATUS frame tick is sticky and cleared by read.
      idle_bus();
      for (int i = 0; i < 4 * D && (n % (4 * D)) != 2; i++) step();
      bus_read(2'd2);
      check("status_tick1", 32'(bus.rdata[2]), 32'h1);
      bus_read(2'd2);
      check("status_tick0", 32'(bus.rdata[2]), 32'h0);

      // Foreign address: ignored, reads zero.
      bus.ren = 1'b1; bus.wen = 1'b1; bus.addr = 32'h0000_00A0;
      bus.wdata = 32'hFFFF_FFFF; bus.wstrb = 4'hF;
      step();
      idle_bus();
      check("foreign_rd", bus.rdata, 32'h0);
      bus_read(2'd0);
      check("foreign_nowr", bus.rdata, 32'h0000_AB00);

      // Same-cycle read and write of DATA returns the old value.
      bus.ren = 1'b1; bus.wen = 1'b1; bus.addr = {24'h0, Base, 4'h0};
      bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF;
      step();
      idle_bus();
      check("rw_old", bus.rdata, 32'h0000_AB00);
      bus_read(2'd0);
      check("rw_new", bus.rdata, 32'h1234_5678);
      bus_read(2'd3);
      check("reg3_rd", bus.rdata, 32'h0);

`ifdef SEG_LEADING_ZERO_BLANK_EN
      bus_write(2'd0, 32'h0000_0050, 4'hF);
      bus_write(2'd1, 32'h0000_0003, 4'hF);
      idle(2 * 4 * D);
      for (int s = 0; s < 4; s++) begin
         wait_sel(4'(1 << s), "blank_sel");
         check("blank_seg0", 32'(seg0), 32'(blank_exp[s]));
         check("blank_seg1", 32'(seg1), 32'h0);
      end
`endif

      // Random bus traffic against the model.
      for (int i = 0; i < 800; i++) begin
         bus.ren   = ($urandom_range(0, 2) == 0);
         bus.wen   = ($urandom_range(0, 2) == 0);
         bus.addr  = {24'($urandom), ($urandom_range(0, 3) == 0) ? 4'hA : Base,
                      2'($urandom), 2'($urandom)};
         bus.wdata = $urandom;
         bus.wstrb = 4'($urandom);
         step();
      end
      idle(4);
      async_reset();
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end
endmodule

// File: doc/seg_display_ctrl.md
Name: seg_display_ctrl

Overview:
- Memory-mapped seven-segment display controller on the router's device-side common bus (common_addr/common_wdata/common_wstrb plus per-device ren/wen).
- Holds an 8-digit hex value and a control register.
- Time-multiplexes digits 0-3 onto seg0/sel0 and digits 4-7 onto seg1/sel1 with a programmable scan rate.
- Read data is returned registered for the router's read mux.

Parameters:
- SCAN_DIV, 50000, clk cycles per digit slot (minimum 2).
- BASE_OFF, 4'h0, value of addr[7:4] that selects this block.

Ports:
- clk  input  1  system clock (PLL output)
- rst_n  input  1  asynchronous active-low reset
- addr  input  32  byte address; addr[7:4] decoded against BASE_OFF, addr[3:2] selects register
- ren  input  1  read request for this device
- rdata  output  32  read data
- wen  input  1  write request for this device
- wdata  input  32  write data
- wstrb  input  4  byte write enables; wstrb[i] covers wdata[8i+7:8i]
- seg0  output  8  segments {dp,g,f,e,d,c,b,a} for digits 0-3, active-high
- seg1  output  8  segments for digits 4-7, active-high
- sel0  output  4  one-hot digit select for digits 0-3, active-high
- sel1  output  4  one-hot digit select for digits 4-7, active-high

Behaviour:
- Reset: one clock (clk), asynchronous active-low reset rst_n; all state clears immediately on rst_n low.
- Reset values: DATA=0, CTRL=0, shadow=0, prescaler=0, slot=0, rdata=0, seg0=seg1=8'h00, sel0=sel1=4'h0.
- Register map (addr[3:2]):
  - 0 DATA: 8 hex nibbles; nibble k goes to digit k.
  - 1 CTRL: bit0 EN; bits[15:8] DP mask (bit 8+k lights dp on digit k); other bits read 0.
  - 2 STATUS: read-only; bits[1:0] current slot, bit2 frame_tick sticky, cleared by read.
  - 3 reads 0; writes ignored.
- Access is valid only when addr[7:4]==BASE_OFF; otherwise the request is ignored and rdata returns 0.
- Write:
  - Takes effect on the clk edge where wen=1.
  - Only bytes with wstrb set are updated.
  - wstrb=0 is a no-op.
- Read:
  - 1-cycle latency: rdata is registered on the edge where ren=1 and holds until the next ren.
  - ren and wen to the same register in the same cycle: rdata returns the pre-write value.
- Scan prescaler:
  - Counts 0..SCAN_DIV-1 and wraps.
  - On wrap, slot increments mod 4.
  - On slot wrap 3->0, shadow<=DATA/CTRL-DP and frame_tick<=1.
  - Writes therefore appear on the display only at frame boundaries; there is no mid-frame tearing.
  - frame_tick read in the same cycle it is set: set wins.
- Outputs, registered and updated each cycle from slot:
  - sel0 = 1<<slot and sel1 = 1<<slot when EN=1; all 0 when EN=0.
  - seg0 = decode(shadow nibble slot) | dp(slot).
  - seg1 = decode(shadow nibble slot+4) | dp(slot+4).
  - When EN=0: segs=0, and the prescaler keeps running.
- Hex decode: 0..F to standard a-g patterns (0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71); dp is bit7.
- rst_n asserted mid-frame: all state returns to reset values immediately; scan restarts at slot 0 after release.

Optional Feature:
- Macro: SEG_LEADING_ZERO_BLANK_EN.
- Defined: CTRL bit1 BLANK is implemented. When BLANK=1, any digit k whose shadow nibbles k..7 are all zero is blanked (seg=dp only), for k>=1. Digit 0 is never blanked.
- Undefined: CTRL bit1 reads 0, writes are ignored, and no blanking occurs.

Test Plan:
- Reset: hold rst_n=0 mid-scan -> all outputs 0 same cycle; after release, first sel0=4'b0001 once EN set.
- Write DATA=32'h7654_3210, CTRL=1, SCAN_DIV=4 -> after next frame boundary, slot0: seg0=3F, seg1=66, sel0=sel1=0001; slot3: seg0=4F, seg1=07, sel0=sel1=1000; each slot lasts 4 cycles.
- Partial write wstrb=4'b0010, wdata=32'h0000_AB00 over DATA=0 -> readback 32'h0000_AB00 one cycle after ren; display changes only at next frame boundary.
- CTRL write 32'h0000_8001 -> digit 7 shows dp: seg1 bit7=1 in slot 3 only.
- Read STATUS after a frame -> bit2=1; a second read -> bit2=0. Read with addr[7:4]!=BASE_OFF -> rdata=0, no register change.
- SEG_LEADING_ZERO_BLANK_EN defined, DATA=32'h0000_0050, CTRL=3 -> digits 2-7 seg=00, digit1=6D, digit0=3F.
